// File: rtl/string_led_pkg.sv
// string_led_pkg: shared state encoding and register map for the string LED Wishbone slice.
package string_led_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wbi_state_e;
  localparam logic [31:0] REG_CONFIG      = 32'h0000_0000;
  localparam logic [31:0] REG_GONSO       = 32'h0000_0004;
  localparam logic [31:0] REG_GONSO_PLUS  = 32'h0000_0008;
  localparam logic [31:0] REG_GONSO_COLOR = 32'h0000_000C;
  localparam int          BUF_WINDOW_BIT  = 12;
endpackage

// File: rtl/string_led_wb_initiator.sv
// string_led_wb_initiator: single-transfer Wishbone classic master with valid/ready command and response.
// Define STRING_LED_WBI_TIMEOUT_EN to abort transfers that see no ack within TIMEOUT cycles.
module string_led_wb_initiator
  import string_led_pkg::*;
#(
  parameter int TSIZE   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        busy,
  output logic        wbs_cyc_o,
  output logic        wbs_stb_o,
  output logic        wbs_we_o,
  output logic [31:0] wbs_adr_o,
  output logic [31:0] wbs_dat_o,
  output logic [3:0]  wbs_sel_o,
  input  logic [31:0] wbs_dat_i,
  input  logic        wbs_ack_i
);
  wbi_state_e  state_q, state_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        rv_q, rv_d;
  logic [31:0] rdat_q, rdat_d;
`ifdef STRING_LED_WBI_TIMEOUT_EN
  logic             err_q, err_d;
  logic [TSIZE-1:0] cnt_q, cnt_d;
`endif
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    rv_d    = rv_q;
    rdat_d  = rdat_q;
`ifdef STRING_LED_WBI_TIMEOUT_EN
    err_d   = err_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = BUS;
        cyc_d   = 1'b1;
        we_d    = cmd_we;
        adr_d   = cmd_adr & ~32'h3;
        dat_d   = cmd_dat;
        sel_d   = cmd_sel;
`ifdef STRING_LED_WBI_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      BUS: if (wbs_ack_i) begin
        // Drop cyc/stb on the ack edge so a one-cycle-late responder cannot see a second strobe.
        state_d = RESP;
        cyc_d   = 1'b0;
        rv_d    = 1'b1;
        rdat_d  = we_q ? 32'h0 : wbs_dat_i;
`ifdef STRING_LED_WBI_TIMEOUT_EN
        err_d   = 1'b0;
      end else if (cnt_q == TSIZE'(TIMEOUT - 1)) begin
        state_d = RESP;
        cyc_d   = 1'b0;
        rv_d    = 1'b1;
        rdat_d  = 32'h0;
        err_d   = 1'b1;
      end else begin
        cnt_d   = cnt_q + 1'b1;
`endif
      end
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        rv_d    = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rv_q    <= 1'b0;
      rdat_q  <= '0;
`ifdef STRING_LED_WBI_TIMEOUT_EN
      err_q   <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rv_q    <= rv_d;
      rdat_q  <= rdat_d;
`ifdef STRING_LED_WBI_TIMEOUT_EN
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`endif
    end
  end
  assign cmd_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign wbs_cyc_o = cyc_q;
  assign wbs_stb_o = cyc_q;
  assign wbs_we_o  = we_q;
  assign wbs_adr_o = adr_q;
  assign wbs_dat_o = dat_q;
  assign wbs_sel_o = sel_q;
  assign rsp_valid = rv_q;
  assign rsp_dat   = rdat_q;
`ifdef STRING_LED_WBI_TIMEOUT_EN
  assign rsp_err   = err_q;
`else
  assign rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_string_led_wb_initiator.sv
// tb_string_led_wb_initiator: randomized self-checking bench with a cycle-level responder and transfer model.
module tb_string_led_wb_initiator;
  import string_led_pkg::*;
  localparam int TMO = 10;
  localparam logic [31:0] BASE = 32'h3000_0000;
  logic        clk = 1'b0, rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err, busy;
  logic [31:0] rsp_dat;
  logic        wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_ack_i = 1'b0;
  logic [31:0] wbs_adr_o, wbs_dat_o, wbs_dat_i = '0;
  logic [3:0]  wbs_sel_o;
  int n_chk = 0, n_fail = 0;
  int obs_stb_n, obs_ack_n, obs_rsp_cyc;
  logic obs_stable, obs_hold_ok, obs_after_ok, obs_done, obs_err;
  logic [31:0] obs_dat;

  string_led_wb_initiator #(.TSIZE(8), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_adr(cmd_adr),
    .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err), .busy(busy),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_we_o(wbs_we_o), .wbs_adr_o(wbs_adr_o),
    .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i)
  );

  always #5 clk = ~clk;

  // Expected outcome of one transfer whose responder acks during strobe cycle lat+1.
  function automatic void model(input logic we, input int lat, input logic [31:0] rdata,
                                output int stb_n, output logic err, output logic [31:0] dat);
`ifdef STRING_LED_WBI_TIMEOUT_EN
    err = (lat + 1) > TMO;
`else
    err = 1'b0;
`endif
    stb_n = err ? TMO : lat + 1;
    dat = (err || we) ? 32'h0 : rdata;
  endfunction

  // Runs one command through the DUT and records what was observed; callers judge the observations.
  task automatic do_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int lat, input logic [31:0] rdata, input int hold);
    int wait_n;
    logic hs;
    obs_stb_n = 0; obs_ack_n = 0; obs_rsp_cyc = -1; obs_dat = 'x; obs_err = 1'bx;
    obs_stable = 1'b1; obs_hold_ok = 1'b1; obs_after_ok = 1'b0; obs_done = 1'b0;
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    @(posedge clk); #1;
    cmd_we = 1'($urandom); cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = 4'($urandom);
    hs = 1'b0; wait_n = 0;
    for (int k = 1; k < 400; k++) begin
      if (hs) begin
        obs_after_ok = cmd_ready && !rsp_valid && !busy;
        obs_done = 1'b1;
        break;
      end
      if (wbs_stb_o) begin
        obs_stb_n++;
        if (!wbs_cyc_o || wbs_we_o !== we || wbs_adr_o !== (adr & ~32'h3) || wbs_dat_o !== dat ||
            wbs_sel_o !== sel || cmd_ready || !busy) obs_stable = 1'b0;
      end
      if (rsp_valid) begin
        if (obs_rsp_cyc < 0) begin
          obs_rsp_cyc = k; obs_dat = rsp_dat; obs_err = rsp_err;
        end else if (rsp_dat !== obs_dat || rsp_err !== obs_err) obs_hold_ok = 1'b0;
        if (cmd_ready || !busy || wbs_stb_o) obs_hold_ok = 1'b0;
        hs = wait_n >= hold;
        wait_n++;
      end
      rsp_ready = hs | (!rsp_valid & 1'($urandom));
      wbs_ack_i = wbs_stb_o ? (obs_stb_n == lat + 1) : 1'($urandom);
      if (wbs_stb_o && wbs_ack_i) obs_ack_n++;
      wbs_dat_i = (wbs_stb_o && wbs_ack_i) ? rdata : $urandom;
      cmd_valid = hs ? 1'b0 : 1'($urandom);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0; wbs_ack_i = 1'b0; cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({wbs_cyc_o, wbs_stb_o, wbs_we_o, rsp_valid, rsp_err, busy, cmd_ready} !== 7'b0000001) begin
      n_fail++; $display("FAIL reset_ctl: got %b want 0000001", {wbs_cyc_o, wbs_stb_o, wbs_we_o, rsp_valid, rsp_err, busy, cmd_ready});
    end
    n_chk++;
    if ({wbs_adr_o, wbs_dat_o, wbs_sel_o, rsp_dat} !== '0) begin
      n_fail++; $display("FAIL reset_data: adr %h dat %h sel %h rsp_dat %h, want all zero", wbs_adr_o, wbs_dat_o, wbs_sel_o, rsp_dat);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: cmd_ready %b busy %b, want 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_write;
    do_xfer(1'b1, BASE | REG_GONSO, 32'h0000_00AB, 4'hF, 1, 32'hDEAD_BEEF, 0);
    n_chk++;
    if (!obs_done || obs_ack_n != 1 || obs_stb_n != 2 || !obs_stable) begin
      n_fail++; $display("FAIL write_bus: done %b acks %0d stb %0d stable %b, want 1 1 2 1", obs_done, obs_ack_n, obs_stb_n, obs_stable);
    end
    n_chk++;
    if (obs_rsp_cyc != 3 || obs_err !== 1'b0 || obs_dat !== 32'h0) begin
      n_fail++; $display("FAIL write_rsp: cycle %0d err %b dat %h, want 3 0 00000000", obs_rsp_cyc, obs_err, obs_dat);
    end
    n_chk++;
    if (wbs_we_o !== 1'b1 || wbs_dat_o !== 32'h0000_00AB || wbs_sel_o !== 4'hF || wbs_cyc_o !== 1'b0) begin
      n_fail++; $display("FAIL write_hold: we %b dat %h sel %h cyc %b, want 1 000000ab f 0", wbs_we_o, wbs_dat_o, wbs_sel_o, wbs_cyc_o);
    end
  endtask

  task automatic test_read;
    do_xfer(1'b0, BASE | REG_GONSO_PLUS | 32'h3, 32'h1234_5678, 4'h3, 1, 32'h0000_00AC, 0);
    n_chk++;
    if (!obs_done || obs_rsp_cyc != 3 || obs_dat !== 32'h0000_00AC || obs_err !== 1'b0) begin
      n_fail++; $display("FAIL read_rsp: done %b cycle %0d dat %h err %b, want 1 3 000000ac 0", obs_done, obs_rsp_cyc, obs_dat, obs_err);
    end
    n_chk++;
    if (obs_stb_n != 2 || obs_ack_n != 1 || !obs_stable) begin
      n_fail++; $display("FAIL read_single: stb %0d acks %0d stable %b, want 2 1 1", obs_stb_n, obs_ack_n, obs_stable);
    end
  endtask

  task automatic test_backpressure;
    do_xfer(1'b0, BASE | REG_GONSO_COLOR, 32'h0, 4'hF, 1, 32'h00C0_FFEE, 5);
    n_chk++;
    if (!obs_done || !obs_hold_ok || obs_dat !== 32'h00C0_FFEE || obs_stb_n != 2) begin
      n_fail++; $display("FAIL bp_hold: done %b hold %b dat %h stb %0d, want 1 1 00c0ffee 2", obs_done, obs_hold_ok, obs_dat, obs_stb_n);
    end
    n_chk++;
    if (!obs_after_ok) begin
      n_fail++; $display("FAIL bp_ready_after: cmd_ready %b rsp_valid %b busy %b, want 1 0 0", cmd_ready, rsp_valid, busy);
    end
  endtask

  task automatic test_wait_states;
    do_xfer(1'b1, BASE | (32'h1 << BUF_WINDOW_BIT) | 32'h40, 32'h5A5A_A5A5, 4'h6, 7, 32'h0, 1);
    n_chk++;
    if (!obs_done || obs_stb_n != 8 || !obs_stable || obs_ack_n != 1) begin
      n_fail++; $display("FAIL wait_bus: done %b stb %0d stable %b acks %0d, want 1 8 1 1", obs_done, obs_stb_n, obs_stable, obs_ack_n);
    end
    n_chk++;
    if (obs_rsp_cyc != 9 || obs_err !== 1'b0 || !obs_hold_ok) begin
      n_fail++; $display("FAIL wait_rsp: cycle %0d err %b hold %b, want 9 0 1", obs_rsp_cyc, obs_err, obs_hold_ok);
    end
  endtask

  task automatic test_timeout;
    int e_stb;
    logic e_err;
    logic [31:0] e_dat;
`ifdef STRING_LED_WBI_TIMEOUT_EN
    int lats [3] = '{50, TMO - 1, TMO - 2};
`else
    int lats [3] = '{30, TMO - 1, TMO};
`endif
    foreach (lats[i]) begin
      model(1'b0, lats[i], 32'hFACE_0000 + 32'(i), e_stb, e_err, e_dat);
      do_xfer(1'b0, BASE | REG_CONFIG, 32'h0, 4'hF, lats[i], 32'hFACE_0000 + 32'(i), 0);
      n_chk++;
      if (!obs_done || obs_stb_n != e_stb || obs_rsp_cyc != e_stb + 1) begin
        n_fail++; $display("FAIL timeout_len[%0d]: done %b stb %0d rsp_cycle %0d, want 1 %0d %0d", i, obs_done, obs_stb_n, obs_rsp_cyc, e_stb, e_stb + 1);
      end
      n_chk++;
      if (obs_err !== e_err || obs_dat !== e_dat) begin
        n_fail++; $display("FAIL timeout_rsp[%0d]: err %b dat %h, want %b %h", i, obs_err, obs_dat, e_err, e_dat);
      end
    end
  endtask

  task automatic test_reset_mid;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = BASE | REG_GONSO; cmd_dat = 32'h77; cmd_sel = 4'hF;
    wbs_ack_i = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (wbs_stb_o !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: stb %b busy %b, want 1 1", wbs_stb_o, busy);
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if (wbs_cyc_o !== 1'b0 || wbs_stb_o !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_async: cyc %b stb %b rsp_valid %b cmd_ready %b, want 0 0 0 1", wbs_cyc_o, wbs_stb_o, rsp_valid, cmd_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_xfer(1'b1, BASE | REG_GONSO, 32'h0000_0099, 4'h1, 1, 32'h0, 0);
    n_chk++;
    if (!obs_done || obs_stb_n != 2 || !obs_stable || obs_err !== 1'b0 || obs_dat !== 32'h0 || !obs_after_ok) begin
      n_fail++; $display("FAIL rstmid_fresh: done %b stb %0d stable %b err %b dat %h after %b", obs_done, obs_stb_n, obs_stable, obs_err, obs_dat, obs_after_ok);
    end
  endtask

  task automatic test_random;
    int e_stb, lat, hold;
    logic e_err, we;
    logic [31:0] e_dat, adr, dat, rdata;
    logic [3:0] sel;
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom); adr = $urandom; dat = $urandom; sel = 4'($urandom); rdata = $urandom;
      lat = $urandom_range(0, 14); hold = $urandom_range(0, 3);
      model(we, lat, rdata, e_stb, e_err, e_dat);
      do_xfer(we, adr, dat, sel, lat, rdata, hold);
      n_chk++;
      if (!obs_done || obs_stb_n != e_stb || obs_ack_n != (e_err ? 0 : 1) || obs_rsp_cyc != e_stb + 1 ||
          obs_err !== e_err || obs_dat !== e_dat || !obs_stable || !obs_hold_ok || !obs_after_ok) begin
        n_fail++;
        $display("FAIL rand[%0d]: we %b lat %0d done %b stb %0d/%0d acks %0d rsp_cycle %0d/%0d err %b/%b dat %h/%h stable %b hold %b after %b",
                 i, we, lat, obs_done, obs_stb_n, e_stb, obs_ack_n, obs_rsp_cyc, e_stb + 1, obs_err, e_err, obs_dat, e_dat,
                 obs_stable, obs_hold_ok, obs_after_ok);
      end
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_backpressure;
    test_wait_states;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
